maxpool2d_backward: RTL

Gradient-routing counterpart of the 2x2/stride-2 max-pool stage in the QuickDraw CNN backward path. It reads the 16x28x28 pre-pool feature maps and the 16x14x14 pooled-output gradients from single-port synchronous RAMs. For each window it recomputes the argmax and writes the 16x28x28 input-gradient map: the pooled gradient goes to the winning position and zero to the other three. It runs once per `start` and sits between the pool1 gradient buffer and the conv1 backward stage.

---
 rtl/pool_pkg.sv | 14 +
 rtl/argmax4.sv | 36 +++
 rtl/maxpool2d_backward.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and default dimensions for the forward and backward 2x2 max-pool stages.
package pool_pkg;

  typedef enum logic [2:0] {IDLE, READ, CMP, WRITE, DONE} pool_bwd_state_t;

  // Window positions in raster order; the enum order doubles as the tie-break priority.
  typedef enum logic [1:0] {TL, TR, BL, BR} win_pos_t;

  localparam int POOL_CH   = 16;
  localparam int POOL_IN_H = 28;
  localparam int POOL_IN_W = 28;
  localparam int POOL_DW   = 32;

endpackage

// File: rtl/argmax4.sv
// Signed argmax over one 2x2 window; the earliest position wins on ties, as in the forward pool.
module argmax4
  import pool_pkg::*;
#(
  parameter int DW = POOL_DW
) (
  input  logic [DW-1:0] tl,
  input  logic [DW-1:0] tr,
  input  logic [DW-1:0] bl,
  input  logic [DW-1:0] br,
  output logic [1:0]    pos
);

  logic [DW-1:0] best;
  win_pos_t      win;

  // Strict greater-than keeps the earlier candidate when values are equal.
  always_comb begin
    best = tl;
    win  = TL;
    if ($signed(tr) > $signed(best)) begin
      best = tr;
      win  = TR;
    end
    if ($signed(bl) > $signed(best)) begin
      best = bl;
      win  = BL;
    end
    if ($signed(br) > $signed(best)) begin
      best = br;
      win  = BR;
    end
    pos = win;
  end

endmodule

// File: rtl/maxpool2d_backward.sv
// Backward pass of the 2x2/stride-2 max-pool: recomputes each window's argmax and routes
// the pooled gradient to the winner, writing zero to the other three positions.
module maxpool2d_backward
  import pool_pkg::*;
#(
  parameter int CH    = POOL_CH,
  parameter int IN_H  = POOL_IN_H,
  parameter int IN_W  = POOL_IN_W,
  parameter int DW    = POOL_DW,
  parameter int OUT_H = IN_H / 2,
  parameter int OUT_W = IN_W / 2,
  parameter int FA    = $clog2(CH * IN_H * IN_W),
  parameter int PA    = $clog2(CH * OUT_H * OUT_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fm_rd_en,
  output logic [FA-1:0] fm_addr,
  input  logic [DW-1:0] fm_rdata,
  output logic          pg_rd_en,
  output logic [PA-1:0] pg_addr,
  input  logic [DW-1:0] pg_rdata,
  output logic          og_we,
  output logic [FA-1:0] og_addr,
  output logic [DW-1:0] og_wdata
);

  localparam int FW = (CH > 1) ? $clog2(CH) : 1;
  localparam int IW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int JW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (((IN_H % 2) != 0) || ((IN_W % 2) != 0)) begin : g_bad_dims
    $error("maxpool2d_backward: IN_H and IN_W must both be even");
  end

  pool_bwd_state_t state, state_nxt;
  logic [2:0]      sub;
  logic [FW-1:0]   f;
  logic [IW-1:0]   i;
  logic [JW-1:0]   j;
  logic [DW-1:0]   v [4];
  logic [DW-1:0]   grad;
  win_pos_t        win;
  logic [1:0]      arg_pos;
  logic            last_win;
  logic [FA-1:0]   fm_base;
  logic [PA-1:0]   pg_base;

  function automatic logic [FA-1:0] pos_offset(input logic [1:0] p);
    case (p)
      2'd0:    pos_offset = '0;
      2'd1:    pos_offset = FA'(1);
      2'd2:    pos_offset = FA'(IN_W);
      default: pos_offset = FA'(IN_W + 1);
    endcase
  endfunction

  argmax4 #(.DW(DW)) u_argmax (
    .tl  (v[0]),
    .tr  (v[1]),
    .bl  (v[2]),
    .br  (v[3]),
    .pos (arg_pos)
  );

  always_comb begin
    fm_base  = FA'(f) * FA'(IN_H * IN_W) + FA'(i) * FA'(2 * IN_W) + FA'({j, 1'b0});
    pg_base  = PA'(f) * PA'(OUT_H * OUT_W) + PA'(i) * PA'(OUT_W) + PA'(j);
    last_win = (f == FW'(CH - 1)) && (i == IW'(OUT_H - 1)) && (j == JW'(OUT_W - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (sub == 3'd4) state_nxt = CMP;
      CMP:     state_nxt = WRITE;
      WRITE:   if (sub == 3'd3) state_nxt = last_win ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each RAM word arrives one cycle after its read, so READ step n captures the value
  // requested at step n-1 and CMP captures the gradient requested in the last READ step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub  <= '0;
      f    <= '0;
      i    <= '0;
      j    <= '0;
      v    <= '{default: '0};
      grad <= '0;
      win  <= TL;
    end else begin
      case (state)
        IDLE: begin
          sub <= '0;
          if (start) begin
            f <= '0;
            i <= '0;
            j <= '0;
          end
        end
        READ: begin
          if (sub != 3'd0) v[sub[1:0] - 2'd1] <= fm_rdata;
          sub <= (sub == 3'd4) ? 3'd0 : sub + 3'd1;
        end
        CMP: begin
          grad <= pg_rdata;
          win  <= win_pos_t'(arg_pos);
          sub  <= '0;
        end
        WRITE: begin
          sub <= (sub == 3'd3) ? 3'd0 : sub + 3'd1;
          if (sub == 3'd3) begin
            if (j == JW'(OUT_W - 1)) begin
              j <= '0;
              if (i == IW'(OUT_H - 1)) begin
                i <= '0;
                f <= (f == FW'(CH - 1)) ? '0 : f + FW'(1);
              end else begin
                i <= i + IW'(1);
              end
            end else begin
              j <= j + JW'(1);
            end
          end
        end
        default: sub <= '0;
      endcase
    end
  end

  // Strobes and addresses decode straight from state, so an asynchronous reset drops them at once.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    fm_rd_en = 1'b0;
    fm_addr  = '0;
    pg_rd_en = 1'b0;
    pg_addr  = '0;
    og_we    = 1'b0;
    og_addr  = '0;
    og_wdata = '0;
    case (state)
      READ: begin
        busy = 1'b1;
        if (sub == 3'd4) begin
          pg_rd_en = 1'b1;
          pg_addr  = pg_base;
        end else begin
          fm_rd_en = 1'b1;
          fm_addr  = fm_base + pos_offset(sub[1:0]);
        end
      end
      CMP: busy = 1'b1;
      WRITE: begin
        busy     = 1'b1;
        og_we    = 1'b1;
        og_addr  = fm_base + pos_offset(sub[1:0]);
        og_wdata = (win_pos_t'(sub[1:0]) == win) ? grad : '0;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
